// File: rtl/result_byte_streamer.sv
// Buffers qualified result words in a FIFO and streams each one out MSB-first as bytes
// over a valid/ready handshake.
module result_byte_streamer #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic                     busy
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     byte_idx;

    logic              full;
    logic              xfer;
    logic              last;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        full    = (fifo_count == CW'(DEPTH));
        xfer    = out_valid && out_ready;
        last    = (byte_idx == IW'(BYTES - 1));
        // The head leaves the FIFO when the FSM is idle, or when the last byte of the
        // current word is accepted, so the next word follows without a bubble.
        pop     = (fifo_count != '0) && ((state == IDLE) || (state == SEND && xfer && last));
        push    = in_valid && (!full || pop);
        drop    = in_valid && !push;
        head    = mem[rd_ptr];
        shifted = shreg << 8;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            byte_idx  <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg     <= head;
                        byte_idx  <= '0;
                        out_valid <= 1'b1;
                        out_byte  <= head[DATA_W-1 -: 8];
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            if (pop) begin
                                shreg    <= head;
                                byte_idx <= '0;
                                out_byte <= head[DATA_W-1 -: 8];
                            end else begin
                                out_valid <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            shreg    <= shifted;
                            byte_idx <= byte_idx + 1'b1;
                            out_byte <= shifted[DATA_W-1 -: 8];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = out_valid || (fifo_count != '0);

endmodule

// File: tb/tb_result_byte_streamer.sv
// Self-checking bench for result_byte_streamer: cycle table for a single word, then
// scoreboarded sequences for backpressure, back-to-back, overflow, full+pop and reset.
module tb_result_byte_streamer;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_valid  = 1'b0;
    logic [39:0] in_data   = '0;
    logic        out_ready = 1'b0;
    logic        clr_ovf   = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb [$];
    logic [7:0]  exp_b;

    typedef struct {
        logic        vin;
        logic [39:0] din;
        logic        rdy;
        logic [7:0]  exp_byte;
        logic        exp_valid;
        logic [4:0]  exp_cnt;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [8];

    result_byte_streamer #(
        .DATA_W(40),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [39:0] w);
        for (int i = 4; i >= 0; i--) begin
            sb.push_back(w[i*8 +: 8]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [39:0] w, input bit accept);
        in_valid = 1'b1;
        in_data  = w;
        if (accept) sb_push(w);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (!busy && !out_valid) break;
            step();
        end
        check({name, "_idle"}, {63'd0, busy}, 64'd0);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Every accepted byte is compared against the scoreboard front.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got byte %0h, expected no byte", out_byte);
            end else begin
                exp_b = sb.pop_front();
                if (out_byte !== exp_b) begin
                    n_err++;
                    $display("FAIL sb_byte: got %0h, expected %0h", out_byte, exp_b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] w;
        logic [39:0] b2b [3];
        int          nvalid;
        int          first_c;
        int          last_c;
        bit          found;

        tbl[0] = '{1'b1, 40'h123456789A, 1'b1, 8'h00, 1'b0, 5'd1, 1'b1};
        tbl[1] = '{1'b0, 40'h0,          1'b1, 8'h12, 1'b1, 5'd0, 1'b1};
        tbl[2] = '{1'b0, 40'h0,          1'b1, 8'h34, 1'b1, 5'd0, 1'b1};
        tbl[3] = '{1'b0, 40'h0,          1'b1, 8'h56, 1'b1, 5'd0, 1'b1};
        tbl[4] = '{1'b0, 40'h0,          1'b1, 8'h78, 1'b1, 5'd0, 1'b1};
        tbl[5] = '{1'b0, 40'h0,          1'b1, 8'h9A, 1'b1, 5'd0, 1'b1};
        tbl[6] = '{1'b0, 40'h0,          1'b1, 8'h9A, 1'b0, 5'd0, 1'b0};
        tbl[7] = '{1'b0, 40'h0,          1'b1, 8'h9A, 1'b0, 5'd0, 1'b0};

        // Reset state
        #12;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_byte", 64'(out_byte), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();

        // Single word, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            in_valid  = tbl[i].vin;
            in_data   = tbl[i].din;
            out_ready = tbl[i].rdy;
            if (tbl[i].vin) sb_push(tbl[i].din);
            step();
            in_valid = 1'b0;
            check($sformatf("row%0d_byte", i), 64'(out_byte), 64'(tbl[i].exp_byte));
            check($sformatf("row%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_valid});
            check($sformatf("row%0d_count", i), 64'(fifo_count), 64'(tbl[i].exp_cnt));
            check($sformatf("row%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].exp_busy});
        end

        // Backpressure while 0x56 is presented
        out_ready = 1'b1;
        push_word(40'h123456789A, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid && out_byte == 8'h56) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("bp_found", {63'd0, found}, 64'd1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("bp_hold_byte%0d", k), 64'(out_byte), 64'h56);
            check($sformatf("bp_hold_valid%0d", k), {63'd0, out_valid}, 64'd1);
        end
        drain("bp");

        // Back-to-back words: 15 contiguous valid bytes
        b2b[0] = 40'h0102030405;
        b2b[1] = 40'h0A0B0C0D0E;
        b2b[2] = 40'hF0F1F2F3F4;
        nvalid  = 0;
        first_c = -1;
        last_c  = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c < 3);
            if (c < 3) begin
                in_data = b2b[c];
                sb_push(b2b[c]);
            end
            step();
            if (out_valid) begin
                nvalid++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        in_valid = 1'b0;
        check("b2b_nvalid", 64'(nvalid), 64'd15);
        check("b2b_span", 64'(last_c - first_c), 64'd14);
        check("b2b_first", 64'(first_c), 64'd1);
        drain("b2b");

        // Overflow: 17 absorbed, 18th dropped
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            w = {8'hA0, 8'(i), 8'hB1, 8'(i), 8'hC2};
            push_word(w, i < 17);
        end
        check("ovf_count", 64'(fifo_count), 64'd16);
        check("ovf_flag", {63'd0, overflow}, 64'd1);
        check("ovf_valid", {63'd0, out_valid}, 64'd1);
        drain("ovf");
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", {63'd0, overflow}, 64'd0);

        // Full FIFO with a pop on the same edge as a push
        out_ready = 1'b0;
        push_word(40'h1122334455, 1'b1);
        for (int i = 0; i < 16; i++) begin
            w = {8'h60 + 8'(i), 8'h70, 8'(i), 8'h80, 8'h90};
            push_word(w, 1'b1);
        end
        check("fp_full", 64'(fifo_count), 64'd16);
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid && out_byte == 8'h55) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("fp_found", {63'd0, found}, 64'd1);
        push_word(40'hDEADBEEF01, 1'b1);
        out_ready = 1'b0;
        check("fp_count", 64'(fifo_count), 64'd16);
        check("fp_ovf", {63'd0, overflow}, 64'd0);
        check("fp_valid", {63'd0, out_valid}, 64'd1);
        check("fp_next_byte", 64'(out_byte), 64'h60);
        drain("fp");

        // Reset mid-word with 3 words queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = {8'h21 + 8'(i), 8'h43, 8'h65, 8'h87, 8'hA9};
            push_word(w, 1'b1);
        end
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        check("rm_pending", 64'(out_byte), 64'h65);
        check("rm_queued", 64'(fifo_count), 64'd3);
        #2 rst = 1'b0;
        #1;
        check("rm_valid", {63'd0, out_valid}, 64'd0);
        check("rm_count", 64'(fifo_count), 64'd0);
        check("rm_ovf", {63'd0, overflow}, 64'd0);
        check("rm_busy", {63'd0, busy}, 64'd0);
        check("rm_byte", 64'(out_byte), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        out_ready = 1'b1;
        push_word(40'hC0FFEE1234, 1'b1);
        step();
        check("rm_restart_byte", 64'(out_byte), 64'hC0);
        drain("rm");
        check("rm_last_byte", 64'(out_byte), 64'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_byte_streamer.md
Name: result_byte_streamer

Overview:
- Sits directly downstream of the processor core and consumes its 40-bit result bus `data`, qualified by `enable`.
- Each qualified result word is buffered in a FIFO, then emitted MSB-first as a stream of bytes over a valid/ready handshake.
- The byte stream feeds the board-level UART/host link.
- Words arriving while the buffer is full are dropped and flagged.

Parameters:
- DATA_W, 40, result word width; must be a multiple of 8.
- DEPTH, 16, FIFO depth in words; power of two, >= 2.
- BYTES, DATA_W/8, derived (5); bytes per word, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  result qualifier (processor `enable`)
- in_data  in  DATA_W  result word (processor `data`)
- out_byte  out  8  current output byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts byte
- fifo_count  out  $clog2(DEPTH)+1  words held in FIFO (excludes word in shift register)
- overflow  out  1  sticky drop flag
- clr_ovf  in  1  clears overflow
- busy  out  1  out_valid OR fifo_count != 0

Behaviour:
- Reset (rst=0, async): out_valid=0, out_byte=0, fifo_count=0, overflow=0, busy=0, FSM=IDLE, FIFO pointers=0.
- Push: at a rising edge with in_valid=1:
  - If fifo_count < DEPTH, the word is written.
  - If fifo_count == DEPTH and a pop occurs in the same cycle, the word is written; count is unchanged.
  - If fifo_count == DEPTH with no pop, the word is dropped and overflow=1.
- overflow stays set until clr_ovf=1. A drop and clr_ovf in the same cycle leaves overflow=1 (set wins).
- Pointers wrap modulo DEPTH. fifo_count updates on the same edge as the push/pop: +1, -1, or unchanged when both occur.
- FSM states: IDLE, SEND.
  - IDLE: if fifo_count != 0, pop the head into the DATA_W shift register, set byte_idx=0, out_valid=1, and go to SEND (all at the same edge).
  - SEND: out_byte = shreg[DATA_W-1 -: 8].
    - A byte transfers when out_valid && out_ready at the rising edge. On transfer, shreg shifts left 8 and byte_idx increments.
    - Transfer with byte_idx == BYTES-1 and fifo_count != 0: pop the next word, reload shreg, set byte_idx=0, keep out_valid=1, stay in SEND. There is no bubble between words.
    - Transfer with byte_idx == BYTES-1 and fifo_count == 0: out_valid=0, go to IDLE.
- While out_valid && !out_ready, out_byte and out_valid are held stable.
- out_byte is registered. In IDLE it holds its last value, except after reset (0).
- Latency: a word pushed at edge E into an empty FIFO with FSM in IDLE gives out_valid=1 after edge E+1, with out_byte = in_data[39:32].
- Capacity: the FIFO plus the shift register holds DEPTH+1 words.
- A push during IDLE with an empty FIFO lands in the FIFO first (no bypass).
- Reset asserted mid-word aborts the word; buffered data is discarded with no partial-byte recovery.

Test Plan:
- Single word, out_ready=1: push 0x123456789A at edge E -> out_valid rises after E+1; bytes 0x12,0x34,0x56,0x78,0x9A on 5 consecutive cycles; then out_valid=0, busy=0.
- Backpressure: same word, out_ready=0 for 3 cycles while 0x56 is presented -> out_byte holds 0x56 and out_valid stays 1 throughout; stream resumes 0x78,0x9A with no byte lost or duplicated.
- Back-to-back: push 0x0102030405, 0x0A0B0C0D0E, 0xF0F1F2F3F4 on consecutive cycles, out_ready=1 -> exactly 15 contiguous valid bytes, in order, with no out_valid gap at word boundaries.
- Overflow: out_ready=0, push 18 distinct words -> 17 absorbed (fifo_count=16 plus one in shreg), 18th dropped, overflow=1. Release ready -> first 17 words emitted in order. Pulse clr_ovf -> overflow=0.
- Full plus simultaneous pop: FIFO full, the last byte of the current word transfers in the same cycle as in_valid=1 -> the new word is accepted, fifo_count stays 16, overflow stays 0.
- Reset mid-word: assert rst low while byte 2 is pending with 3 words queued -> out_valid, fifo_count, overflow and busy are 0 immediately (async). After release, a fresh push streams correctly from byte 0.
